// File: rtl/sha256_compress.sv
// -----------------------------------------------------------------------------
// sha256_compress
//
// Compression stage of the SHA-256 core. Accepts the 64-word message schedule
// W_t (one word per transfer), runs the 64 compression rounds on the working
// variables a..h, folds the result into the chaining hash H0..H7 and presents
// the 256-bit digest with a one-cycle valid pulse.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   start_in     begin a block (only honoured in IDLE)
//   i_first      with start_in: 1 = load standard IV, 0 = chain from current H
//   i_sha224     (only when SHA224_EN is defined) with start_in && i_first:
//                1 = load the SHA-224 IV instead of the SHA-256 IV
//   w_in         message schedule word W_t
//   w_valid_in   w_in valid this cycle
//   w_ready_out  high in ROUND; a word transfers on w_valid_in && w_ready_out
//   o_digest     {H0..H7}, H0 in [255:224]; SHA-224 digest is [255:32]
//   dout_valid   one-cycle pulse when o_digest is updated
//   o_busy       state != IDLE
//   o_FSM_state  current state (IDLE=00, ROUND=01, FINAL=10)
//   o_round      index of the next W word to consume
//
// Configuration macro: SHA224_EN (adds i_sha224 and the SHA-224 IV).
// DATA_WIDTH must be 32; the round arithmetic is fixed SHA-256 32-bit math.
// -----------------------------------------------------------------------------
module sha256_compress #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_in,
  input  logic                    i_first,
`ifdef SHA224_EN
  input  logic                    i_sha224,
`endif
  input  logic [DATA_WIDTH-1:0]   w_in,
  input  logic                    w_valid_in,
  output logic                    w_ready_out,
  output logic [8*DATA_WIDTH-1:0] o_digest,
  output logic                    dout_valid,
  output logic                    o_busy,
  output logic [1:0]              o_FSM_state,
  output logic [5:0]              o_round
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ROUND = 2'b01,
    FINAL = 2'b10
  } state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV_256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV_224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  state_t      state_r;
  logic [5:0]  round_r;
  logic        ready_r;
  logic        busy_r;
  logic [31:0] wv_r   [8];   // working variables a..h at indices 0..7
  logic [31:0] hash_r [8];   // chaining hash H0..H7

  logic        use224_s;
  logic [31:0] iv_s   [8];
  logic [31:0] t1_s;
  logic [31:0] t2_s;
  logic [31:0] sum_s  [8];

`ifdef SHA224_EN
  assign use224_s = i_sha224;
`else
  assign use224_s = 1'b0;
`endif

  assign w_ready_out = ready_r;
  assign o_busy      = busy_r;
  assign o_FSM_state = state_r;
  assign o_round     = round_r;

  // Initial value selection for a fresh (i_first) block.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (use224_s) begin
        iv_s[i] = IV_224[i];
      end else begin
        iv_s[i] = IV_256[i];
      end
    end
  end

  // One compression round: T1/T2 from current a..h, K[round] and W_t.
  always_comb begin
    t1_s = wv_r[7] + big_sigma1(wv_r[4]) + ch(wv_r[4], wv_r[5], wv_r[6])
         + K_ROM[round_r] + w_in;
    t2_s = big_sigma0(wv_r[0]) + maj(wv_r[0], wv_r[1], wv_r[2]);
  end

  // Chaining-hash update values used in FINAL.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      sum_s[i] = hash_r[i] + wv_r[i];
    end
  end

  // Block-level FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      round_r    <= 6'd0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      dout_valid <= 1'b0;
      o_digest   <= '0;
      for (int i = 0; i < 8; i++) begin
        wv_r[i]   <= 32'd0;
        hash_r[i] <= 32'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          dout_valid <= 1'b0;
          if (start_in) begin
            if (i_first) begin
              for (int i = 0; i < 8; i++) begin
                hash_r[i] <= iv_s[i];
                wv_r[i]   <= iv_s[i];
              end
            end else begin
              for (int i = 0; i < 8; i++) begin
                wv_r[i] <= hash_r[i];
              end
            end
            round_r <= 6'd0;
            ready_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ROUND;
          end
        end

        ROUND: begin
          dout_valid <= 1'b0;
          if (w_valid_in && ready_r) begin
            wv_r[7] <= wv_r[6];
            wv_r[6] <= wv_r[5];
            wv_r[5] <= wv_r[4];
            wv_r[4] <= wv_r[3] + t1_s;
            wv_r[3] <= wv_r[2];
            wv_r[2] <= wv_r[1];
            wv_r[1] <= wv_r[0];
            wv_r[0] <= t1_s + t2_s;
            // 6-bit counter wraps 63 -> 0 on the last word.
            round_r <= round_r + 6'd1;
            if (round_r == 6'd63) begin
              ready_r <= 1'b0;
              state_r <= FINAL;
            end
          end
        end

        FINAL: begin
          for (int i = 0; i < 8; i++) begin
            hash_r[i] <= sum_s[i];
          end
          o_digest   <= {sum_s[0], sum_s[1], sum_s[2], sum_s[3],
                         sum_s[4], sum_s[5], sum_s[6], sum_s[7]};
          dout_valid <= 1'b1;
          ready_r    <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end

        default: begin
          // Unused encoding: recover to IDLE without touching the hash.
          dout_valid <= 1'b0;
          ready_r    <= 1'b0;
          busy_r     <= 1'b0;
          round_r    <= 6'd0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress.sv
// -----------------------------------------------------------------------------
// tb_sha256_compress
//
// Directed-vector bench for sha256_compress. Builds the 64-word message
// schedule for each padded block locally and feeds it to the DUT, comparing
// digests against known SHA-256 (and, with SHA224_EN, SHA-224) results.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sha256_compress;

  logic         clk;
  logic         rst_n;
  logic         start_in;
  logic         i_first;
`ifdef SHA224_EN
  logic         i_sha224;
`endif
  logic [31:0]  w_in;
  logic         w_valid_in;
  logic         w_ready_out;
  logic [255:0] o_digest;
  logic         dout_valid;
  logic         o_busy;
  logic [1:0]   o_FSM_state;
  logic [5:0]   o_round;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] msg     [16];
  logic [31:0] w_sched [64];

  sha256_compress #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_in    (start_in),
    .i_first     (i_first),
`ifdef SHA224_EN
    .i_sha224    (i_sha224),
`endif
    .w_in        (w_in),
    .w_valid_in  (w_valid_in),
    .w_ready_out (w_ready_out),
    .o_digest    (o_digest),
    .dout_valid  (dout_valid),
    .o_busy      (o_busy),
    .o_FSM_state (o_FSM_state),
    .o_round     (o_round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic clear_msg();
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
  endtask

  // Standard SHA-256 message schedule expansion of msg[] into w_sched[].
  task automatic expand_sched();
    logic [31:0] s0;
    logic [31:0] s1;
    for (int t = 0; t < 16; t++) w_sched[t] = msg[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w_sched[t-15], 7) ^ rotr(w_sched[t-15], 18) ^ (w_sched[t-15] >> 3);
      s1 = rotr(w_sched[t-2], 17) ^ rotr(w_sched[t-2], 19) ^ (w_sched[t-2] >> 10);
      w_sched[t] = s1 + w_sched[t-7] + s0 + w_sched[t-16];
    end
  endtask

  task automatic load_abc();
    clear_msg();
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    expand_sched();
  endtask

  // Feeds one block; tracks transfers independently and checks o_round.
  task automatic run_block(input logic first, input int stall_pct, input bit extra_start,
                           input int abort_at, output logic [255:0] dig, output int lat,
                           output bit aborted);
    int  idx;
    int  cyc;
    bit  done;
    logic rdy;
    idx = 0; cyc = 0; done = 1'b0; aborted = 1'b0; dig = '0; lat = 0;
    @(negedge clk);
    start_in   = 1'b1;
    i_first    = first;
    w_valid_in = 1'b0;
    @(posedge clk);
    cyc = 1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      if (dout_valid) begin
        dig  = o_digest;
        lat  = cyc;
        done = 1'b1;
      end else begin
        check_val("round_track", {250'd0, o_round}, {250'd0, 6'(idx)});
        if (abort_at >= 0 && idx == abort_at) begin
          aborted = 1'b1;
          done    = 1'b1;
        end else begin
          rdy        = w_ready_out;
          w_valid_in = ($urandom_range(99) >= stall_pct);
          w_in       = w_sched[(idx < 64) ? idx : 0];
          start_in   = extra_start && (idx > 1) && (idx < 60);
          @(posedge clk);
          cyc++;
          if (w_valid_in && rdy) idx++;
        end
      end
    end
    start_in   = 1'b0;
    w_valid_in = 1'b0;
    if (!done) check_val("timeout", 256'd0, 256'd1);
  endtask

  logic [255:0] dig;
  logic [255:0] held;
  logic [223:0] dig224;
  int           lat;
  bit           ab;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIGEST =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  initial begin
    rst_n = 1'b0; start_in = 1'b0; i_first = 1'b0; w_in = 32'd0; w_valid_in = 1'b0;
`ifdef SHA224_EN
    i_sha224 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_digest", o_digest, 256'd0);
    check_val("rst_valid",  {255'd0, dout_valid}, 256'd0);
    check_val("rst_busy",   {255'd0, o_busy}, 256'd0);
    check_val("rst_ready",  {255'd0, w_ready_out}, 256'd0);
    check_val("rst_state",  {254'd0, o_FSM_state}, 256'd0);
    check_val("rst_round",  {250'd0, o_round}, 256'd0);
    rst_n = 1'b1;

    // w_valid_in in IDLE must not consume anything.
    w_valid_in = 1'b1; w_in = 32'hdeadbeef;
    repeat (3) @(negedge clk);
    check_val("idle_round", {250'd0, o_round}, 256'd0);
    check_val("idle_state", {254'd0, o_FSM_state}, 256'd0);
    check_val("idle_ready", {255'd0, w_ready_out}, 256'd0);
    w_valid_in = 1'b0;

    // "abc", no stalls: digest and 66-cycle latency.
    load_abc();
    run_block(1'b1, 0, 1'b0, -1, dig, lat, ab);
    check_val("abc_digest", dig, ABC_DIGEST);
    check_val("abc_latency", 256'(lat), 256'd66);
    held = dig;
    @(negedge clk);
    check_val("pulse_len", {255'd0, dout_valid}, 256'd0);
    check_val("post_busy", {255'd0, o_busy}, 256'd0);
    check_val("digest_hold", o_digest, held);

    // Empty message.
    clear_msg();
    msg[0] = 32'h80000000;
    expand_sched();
    run_block(1'b1, 0, 1'b0, -1, dig, lat, ab);
    check_val("empty_digest", dig, EMPTY_DIGEST);

    // Two-block message, second block chains from H.
    msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    expand_sched();
    run_block(1'b1, 0, 1'b0, -1, dig, lat, ab);
    clear_msg();
    msg[15] = 32'h000001c0;
    expand_sched();
    run_block(1'b0, 0, 1'b0, -1, dig, lat, ab);
    check_val("two_block_digest", dig, TWO_DIGEST);

    // "abc" with ~30% stalls and spurious start pulses while busy.
    load_abc();
    run_block(1'b1, 30, 1'b1, -1, dig, lat, ab);
    check_val("stall_digest", dig, ABC_DIGEST);

    // Abort at round 20 with reset, then a clean rerun.
    run_block(1'b1, 0, 1'b0, 20, dig, lat, ab);
    check_val("abort_reached", {255'd0, ab}, 256'd1);
    rst_n = 1'b0;
    #1;
    check_val("abort_digest", o_digest, 256'd0);
    check_val("abort_state",  {254'd0, o_FSM_state}, 256'd0);
    check_val("abort_round",  {250'd0, o_round}, 256'd0);
    check_val("abort_busy",   {255'd0, o_busy}, 256'd0);
    check_val("abort_ready",  {255'd0, w_ready_out}, 256'd0);
    check_val("abort_valid",  {255'd0, dout_valid}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(1'b1, 0, 1'b0, -1, dig, lat, ab);
    check_val("rerun_digest", dig, ABC_DIGEST);

`ifdef SHA224_EN
    i_sha224 = 1'b1;
    run_block(1'b1, 0, 1'b0, -1, dig, lat, ab);
    i_sha224 = 1'b0;
    dig224 = dig[255:32];
    check_val("sha224_digest", {32'd0, dig224},
              {32'd0, 224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7});
`else
    dig224 = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
